// File: rtl/tohost_if.sv
// Core data-memory write snoop plus verdict handshake
// for the riscv-tests tohost monitor.
interface tohost_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_code;
  logic [30:0] fail_id;
  logic [31:0] cycle_count;
  logic [15:0] ignored_count;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output res_ready,
    input  res_valid,
    input  res_code,
    input  fail_id,
    input  cycle_count,
    input  ignored_count
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  res_ready,
    output res_valid,
    output res_code,
    output fail_id,
    output cycle_count,
    output ignored_count
  );
endinterface

// File: rtl/tohost_monitor.sv
// Watches tohost writes and reports pass/fail/timeout
// through a valid/ready verdict handshake.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          TIMEOUT     = 5000
) (
  input logic     clk,
  input logic     rst,
  tohost_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    REPORT,
    DONE
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_PASS = 2'b01;
  localparam logic [1:0] CODE_FAIL = 2'b10;
  localparam logic [1:0] CODE_TOUT = 2'b11;

  localparam logic [31:0] LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic        valid;
  logic [1:0]  code;
  logic [30:0] id;
  logic [31:0] cnt;
  logic [15:0] ign;

  logic hit;
  logic nz;
  logic done_wr;

  assign hit     = bus.mem_we &&
                   (bus.mem_addr == TOHOST_ADDR);
  assign nz      = (bus.mem_wdata != 32'd0);
  assign done_wr = hit && nz && bus.mem_wdata[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      valid <= 1'b0;
      code  <= CODE_NONE;
      id    <= '0;
      cnt   <= '0;
      ign   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (cnt != 32'hFFFF_FFFF)
            cnt <= cnt + 32'd1;
          if (hit && nz && !bus.mem_wdata[0] &&
              ign != 16'hFFFF)
            ign <= ign + 16'd1;
          // A completing write beats a same-cycle timeout
          if (done_wr) begin
            state <= REPORT;
            valid <= 1'b1;
            id    <= bus.mem_wdata[31:1];
            code  <= (bus.mem_wdata[31:1] == '0)
                     ? CODE_PASS : CODE_FAIL;
          end else if (cnt == LAST) begin
            state <= REPORT;
            valid <= 1'b1;
            id    <= '0;
            code  <= CODE_TOUT;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state <= DONE;
            valid <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
          state <= DONE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_valid     = valid;
  assign bus.res_code      = code;
  assign bus.fail_id       = id;
  assign bus.cycle_count   = cnt;
  assign bus.ignored_count = ign;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed checks of the tohost monitor verdicts,
// filtering, timeout and asynchronous reset.
module tb_tohost_monitor;

  localparam logic [31:0] TA = 32'h0000_1000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tohost_if bus ();

  tohost_monitor #(
    .TOHOST_ADDR(TA),
    .TIMEOUT(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic v,
                      input logic [1:0] c,
                      input logic [30:0] f,
                      input logic [31:0] cc,
                      input logic [15:0] ic);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({tag, ".code"}, 32'(bus.res_code), 32'(c));
    chk({tag, ".fail_id"}, 32'(bus.fail_id), 32'(f));
    chk({tag, ".cycles"}, bus.cycle_count, cc);
    chk({tag, ".ignored"}, 32'(bus.ignored_count),
        32'(ic));
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    @(negedge clk);
    bus.mem_we    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // pass on cycle 20 with delayed accept
    do_reset();
    outs("rst", 0, 2'b00, 0, 0, 0);
    repeat (20) @(negedge clk);
    outs("pre20", 0, 2'b00, 0, 20, 0);
    wr(TA, 32'h1);
    outs("pass", 1, 2'b01, 0, 21, 0);
    repeat (3) begin
      @(negedge clk);
      outs("hold", 1, 2'b01, 0, 21, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    outs("pdone", 0, 2'b01, 0, 21, 0);
    wr(TA, 32'h7);
    outs("pdone_wr", 0, 2'b01, 0, 21, 0);

    // fail id 3, later writes ignored
    do_reset();
    repeat (5) @(negedge clk);
    wr(TA, 32'h0000_0007);
    outs("fail", 1, 2'b10, 3, 6, 0);
    wr(TA, 32'h1);
    outs("rep_wr1", 1, 2'b10, 3, 6, 0);
    wr(TA, 32'h40);
    outs("rep_wr40", 1, 2'b10, 3, 6, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    wr(TA, 32'h1);
    outs("fdone", 0, 2'b10, 3, 6, 0);

    // timeout at 50
    do_reset();
    repeat (49) @(negedge clk);
    outs("pre_to", 0, 2'b00, 0, 49, 0);
    @(negedge clk);
    outs("tout", 1, 2'b11, 0, 50, 0);
    repeat (5) @(negedge clk);
    outs("tout_hold", 1, 2'b11, 0, 50, 0);

    // fail write on cycle 49 beats timeout
    do_reset();
    repeat (49) @(negedge clk);
    wr(TA, 32'h0000_000B);
    outs("prio", 1, 2'b10, 5, 50, 0);

    // filtering, ready in RUN has no effect
    do_reset();
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    wr(TA, 32'h0);
    outs("clr", 0, 2'b00, 0, 4, 0);
    wr(TA, 32'h40);
    outs("even", 0, 2'b00, 0, 5, 1);
    wr(TA + 32'd4, 32'h1);
    outs("addr4", 0, 2'b00, 0, 6, 1);
    bus.res_ready = 1'b0;

    // async reset while reporting
    do_reset();
    repeat (2) @(negedge clk);
    wr(TA, 32'h1);
    outs("r_pass", 1, 2'b01, 0, 3, 0);
    #2 rst = 1'b1;
    #1 outs("async", 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wr(TA, 32'h1);
    outs("repass", 1, 2'b01, 0, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 Parameter: TOHOST_ADDR, 32'h0000_1000, byte address of the riscv-tests tohost word.
REQ-002 Parameter: TIMEOUT, 5000, cycles after reset release before a timeout verdict.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: mem_we  input  1  core data-memory write strobe, one write per cycle when high.
REQ-006 Port: mem_addr  input  32  core data-memory write byte address.
REQ-007 Port: mem_wdata  input  32  core data-memory write data.
REQ-008 Port: res_valid  output  1  verdict available.
REQ-009 Port: res_ready  input  1  bench accepts the verdict.
REQ-010 Port: res_code  output  2  verdict: 2'b01 pass, 2'b10 fail, 2'b11 timeout, 2'b00 none.
REQ-011 Port: fail_id  output  31  failing test number (tohost[31:1]); 0 unless res_code is fail.
REQ-012 Port: cycle_count  output  32  cycles elapsed since reset release, frozen at verdict.
REQ-013 Port: ignored_count  output  16  tohost writes with LSB 0 and nonzero data.

Function
REQ-014 FSM states RUN, REPORT, DONE; the SHALL be exactly these three.
REQ-015 RUN: cycle_count SHALL increment by 1 each cycle, saturating at 32'hFFFF_FFFF.
REQ-016 Tohost hit SHALL be mem_we=1 and mem_addr==TOHOST_ADDR (full 32-bit compare, no masking).
REQ-017 Hit with mem_wdata==0 SHALL be ignored with no state or counter change (tohost clear).
REQ-018 Hit with mem_wdata[0]=0, nonzero data: ignored_count SHALL increment, saturating at 16'hFFFF; FSM stays in RUN.
REQ-019 Hit with mem_wdata==32'h1 in RUN: next cycle res_code=01, fail_id=0, FSM -> REPORT.
REQ-020 Hit with mem_wdata[0]=1 and mem_wdata[31:1]!=0 in RUN: next cycle res_code=10, fail_id=mem_wdata[31:1], FSM -> REPORT.
REQ-021 In RUN, when cycle_count equals TIMEOUT-1 with no hit that cycle: next cycle res_code=11, fail_id=0, FSM -> REPORT.
REQ-022 Hit and timeout in the same cycle: the hit SHALL take priority over the timeout.
REQ-023 The cycle_count update on the verdict cycle SHALL still apply; afterwards cycle_count SHALL hold.
REQ-024 res_valid SHALL be 1 exactly in REPORT; res_code, fail_id stable while res_valid=1.
REQ-025 REPORT: when res_ready=1 at a rising edge, FSM -> DONE and res_valid deasserts next cycle.
REQ-026 REPORT with res_ready=0: SHALL hold indefinitely; no timeout, no further decode.
REQ-027 In REPORT and DONE, all tohost writes SHALL be ignored, including ignored_count updates.
REQ-028 DONE: res_code and fail_id SHALL keep their verdict values; DONE is left only by reset.
REQ-029 res_ready while in RUN or DONE SHALL have no effect.
REQ-030 Latency: verdict visible on res_valid one cycle after the qualifying write or timeout cycle.

Reset
REQ-031 rst=1 SHALL immediately force RUN, res_valid=0, res_code=00, fail_id=0, cycle_count=0, ignored_count=0.
REQ-032 Reset asserted in any state, including REPORT mid-handshake, SHALL discard the verdict.
REQ-033 First count increment SHALL occur on the first rising edge with rst=0.

Verification
REQ-034 Pass: release reset, write 32'h1 to TOHOST_ADDR on cycle 20, hold res_ready=0 for 3 cycles -> res_valid=1 from cycle 21 until handshake, res_code=01, cycle_count=21 held.
REQ-035 Fail: write 32'h0000_0007 to TOHOST_ADDR -> res_code=10, fail_id=3; a later write of 32'h1 leaves the verdict unchanged.
REQ-036 Timeout: TIMEOUT=50, no writes -> res_valid rises after cycle 49, res_code=11, cycle_count=50; hit on cycle 49 instead -> hit verdict wins.
REQ-037 Filtering: writes 32'h0, 32'h0000_0040, and 32'h1 to TOHOST_ADDR+4 -> ignored_count=1, no verdict, FSM remains RUN.
REQ-038 Reset: assert rst while res_valid=1 -> all outputs zero asynchronously; a new 32'h1 write then yields pass.
